// File: rtl/comp_scan_pkg.sv
// Shared definitions for the serial arg-min/arg-max scan engine:
// FSM state encodings and the selection-mode constants.
package comp_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    localparam logic SEL_GREAT = 1'b1;
    localparam logic SEL_SMALL = 1'b0;

endpackage

// File: rtl/comperator_scan_upd.sv
// Combinational replace decision for one accumulator slot.
// A candidate wins only if it carries valid data and either the slot is
// empty or its [hi:lo] field is strictly better in the selected direction,
// so ties always keep the element that arrived first.
module comperator_scan_upd
    import comp_scan_pkg::*;
#(
    parameter int data_wd = 16,
    parameter int hi      = 15,
    parameter int lo      = 0
) (
    input  logic [data_wd-1:0] best_dat,
    input  logic               best_dv,
    input  logic [data_wd-1:0] cand_dat,
    input  logic               cand_dv,
    input  logic               mode,
    output logic               replace
);

    logic [hi-lo:0] best_fld_s;
    logic [hi-lo:0] cand_fld_s;

    assign best_fld_s = best_dat[hi:lo];
    assign cand_fld_s = cand_dat[hi:lo];

    // Decide whether the candidate displaces the current slot contents
    always_comb begin
        replace = 1'b0;
        if (!cand_dv) begin
            replace = 1'b0;
        end else if (!best_dv) begin
            replace = 1'b1;
        end else if (mode == SEL_GREAT) begin
            replace = (cand_fld_s > best_fld_s);
        end else if (mode == SEL_SMALL) begin
            replace = (cand_fld_s < best_fld_s);
        end else begin
            replace = 1'b0;
        end
    end

endmodule

// File: rtl/comperator_scan_ctrl.sv
// Sequential arg-min/arg-max engine: scans one frame of metrics over a
// valid/ready stream, keeps the running best in registers and presents it
// on a result handshake.
// Optional macro COMP_SCAN_SECOND_EN adds a runner-up result (res2_*).
module comperator_scan_ctrl
    import comp_scan_pkg::*;
#(
    parameter int data_wd = 16,
    parameter int idx_wd  = 4,
    parameter int hi      = 15,
    parameter int lo      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [idx_wd:0]    cfg_len,
    input  logic               cfg_great_n_small,
    input  logic [data_wd-1:0] in_dat,
    input  logic               in_dv,
    input  logic               in_vld,
    output logic               in_rdy,
    output logic [data_wd-1:0] res_dat,
    output logic [idx_wd-1:0]  res_idx,
    output logic               res_dv,
    output logic               res_vld,
    input  logic               res_rdy,
`ifdef COMP_SCAN_SECOND_EN
    output logic [data_wd-1:0] res2_dat,
    output logic [idx_wd-1:0]  res2_idx,
    output logic               res2_dv,
`endif
    output logic               busy
);

    localparam int cnt_wd = idx_wd + 1;

    scan_state_t          state_r;
    scan_state_t          state_nxt_s;
    logic [cnt_wd-1:0]    cnt_r;
    logic [cnt_wd-1:0]    len_r;
    logic                 mode_r;
    logic [data_wd-1:0]   best_dat_r;
    logic [idx_wd-1:0]    best_idx_r;
    logic                 best_dv_r;
    logic                 in_rdy_r;
    logic                 res_vld_r;
    logic                 busy_r;
    logic                 start_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 repl_best_s;

    // Counter has one extra bit so a full 2^idx_wd frame never wraps early
    assign start_s  = (state_r == ST_IDLE) && start;
    assign accept_s = (state_r == ST_SCAN) && in_vld && in_rdy_r;
    assign last_s   = (cnt_r == (len_r - cnt_wd'(1)));

    comperator_scan_upd #(
        .data_wd (data_wd),
        .hi      (hi),
        .lo      (lo)
    ) u_upd_best (
        .best_dat (best_dat_r),
        .best_dv  (best_dv_r),
        .cand_dat (in_dat),
        .cand_dv  (in_dv),
        .mode     (mode_r),
        .replace  (repl_best_s)
    );

    // Next-state logic of the IDLE/SCAN/DONE controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != cnt_wd'(0)) begin
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (res_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            in_rdy_r  <= 1'b0;
            res_vld_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            in_rdy_r  <= (state_nxt_s == ST_SCAN);
            res_vld_r <= (state_nxt_s == ST_DONE);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Config latch, beat counter and best-element accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            len_r      <= '0;
            mode_r     <= SEL_SMALL;
            best_dat_r <= '0;
            best_idx_r <= '0;
            best_dv_r  <= 1'b0;
        end else if (start_s) begin
            cnt_r      <= '0;
            len_r      <= cfg_len;
            mode_r     <= cfg_great_n_small;
            best_dat_r <= '0;
            best_idx_r <= '0;
            best_dv_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + cnt_wd'(1);
            if (repl_best_s) begin
                best_dat_r <= in_dat;
                best_idx_r <= cnt_r[idx_wd-1:0];
                best_dv_r  <= 1'b1;
            end
        end
    end

`ifdef COMP_SCAN_SECOND_EN
    logic [data_wd-1:0] sec_dat_r;
    logic [idx_wd-1:0]  sec_idx_r;
    logic               sec_dv_r;
    logic               repl_sec_s;

    comperator_scan_upd #(
        .data_wd (data_wd),
        .hi      (hi),
        .lo      (lo)
    ) u_upd_sec (
        .best_dat (sec_dat_r),
        .best_dv  (sec_dv_r),
        .cand_dat (in_dat),
        .cand_dv  (in_dv),
        .mode     (mode_r),
        .replace  (repl_sec_s)
    );

    // Runner-up slot: a new winner demotes the old best, else strict update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_dat_r <= '0;
            sec_idx_r <= '0;
            sec_dv_r  <= 1'b0;
        end else if (start_s) begin
            sec_dat_r <= '0;
            sec_idx_r <= '0;
            sec_dv_r  <= 1'b0;
        end else if (accept_s) begin
            if (repl_best_s) begin
                sec_dat_r <= best_dat_r;
                sec_idx_r <= best_idx_r;
                sec_dv_r  <= best_dv_r;
            end else if (repl_sec_s) begin
                sec_dat_r <= in_dat;
                sec_idx_r <= cnt_r[idx_wd-1:0];
                sec_dv_r  <= 1'b1;
            end
        end
    end

    assign res2_dat = sec_dat_r;
    assign res2_idx = sec_idx_r;
    assign res2_dv  = sec_dv_r;
`endif

    assign in_rdy  = in_rdy_r;
    assign res_vld = res_vld_r;
    assign busy    = busy_r;
    assign res_dat = best_dat_r;
    assign res_idx = best_idx_r;
    assign res_dv  = best_dv_r;

endmodule

// File: tb/tb_comperator_scan_ctrl.sv
// Directed self-checking bench for comperator_scan_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_comperator_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_len;
    logic        cfg_great_n_small;
    logic [15:0] in_dat;
    logic        in_dv;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] res_dat;
    logic [3:0]  res_idx;
    logic        res_dv;
    logic        res_vld;
    logic        res_rdy;
    logic        busy;
`ifdef COMP_SCAN_SECOND_EN
    logic [15:0] res2_dat;
    logic [3:0]  res2_idx;
    logic        res2_dv;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] vdat [16];
    logic        vdv  [16];

    comperator_scan_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .cfg_len           (cfg_len),
        .cfg_great_n_small (cfg_great_n_small),
        .in_dat            (in_dat),
        .in_dv             (in_dv),
        .in_vld            (in_vld),
        .in_rdy            (in_rdy),
        .res_dat           (res_dat),
        .res_idx           (res_idx),
        .res_dv            (res_dv),
        .res_vld           (res_vld),
        .res_rdy           (res_rdy),
`ifdef COMP_SCAN_SECOND_EN
        .res2_dat          (res2_dat),
        .res2_idx          (res2_idx),
        .res2_dv           (res2_dv),
`endif
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input int len, input logic mode);
        start             = 1'b1;
        cfg_len           = 5'(len);
        cfg_great_n_small = mode;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feed n elements from vdat/vdv; optionally insert an idle cycle between beats
    task automatic send_frame(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_vld = 1'b1;
            in_dat = vdat[i];
            in_dv  = vdv[i];
            @(negedge clk);
            if (i == n - 2) chk("vld_early", 32'(res_vld), 32'd0);
            if (gap && i < n - 1) begin
                in_vld = 1'b0;
                in_dat = 16'hdead;
                @(negedge clk);
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic check_res(input string tag, input int dat, input int idx, input int dv);
        chk({tag, "_vld"}, 32'(res_vld), 32'd1);
        chk({tag, "_dat"}, 32'(res_dat), 32'(dat));
        chk({tag, "_idx"}, 32'(res_idx), 32'(idx));
        chk({tag, "_dv"},  32'(res_dv),  32'(dv));
    endtask

    task automatic handshake(input string tag);
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk({tag, "_hs_vld"},  32'(res_vld), 32'd0);
        chk({tag, "_hs_busy"}, 32'(busy),    32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; in_vld = 1'b1; in_dv = 1'b1; in_dat = 16'd5;
        cfg_len = 5'd3; cfg_great_n_small = 1'b1; res_rdy = 1'b0;

        // Reset held with start and in_vld asserted
        repeat (3) @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_res_dat", 32'(res_dat), 32'd0);
        chk("rst_res_idx", 32'(res_idx), 32'd0);
        chk("rst_res_dv", 32'(res_dv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_rdy", 32'(in_rdy), 32'd0);
        chk("idle_res_vld", 32'(res_vld), 32'd0);
        in_vld = 1'b0;

        // Min mode, tie keeps earlier element
        vdat[0] = 16'd7; vdat[1] = 16'd3; vdat[2] = 16'd9; vdat[3] = 16'd3;
        for (int i = 0; i < 4; i++) vdv[i] = 1'b1;
        start_frame(4, 1'b0);
        chk("min_busy", 32'(busy), 32'd1);
        chk("min_in_rdy", 32'(in_rdy), 32'd1);
        send_frame(4, 1'b0);
        check_res("min", 3, 1, 1);
        chk("min_done_in_rdy", 32'(in_rdy), 32'd0);
        handshake("min");

        // Max mode, full-length frame, last element invalid
        for (int i = 0; i < 16; i++) begin
            vdat[i] = 16'(i * 5);
            vdv[i]  = (i != 15);
        end
        start_frame(16, 1'b1);
        send_frame(16, 1'b0);
        check_res("max16", 70, 14, 1);
        handshake("max16");

        // All elements invalid
        vdat[0] = 16'd100; vdat[1] = 16'd200; vdat[2] = 16'd300;
        for (int i = 0; i < 3; i++) vdv[i] = 1'b0;
        start_frame(3, 1'b1);
        send_frame(3, 1'b0);
        check_res("nodv", 0, 0, 0);
        handshake("nodv");

        // Zero-length frame goes straight to DONE
        start_frame(0, 1'b1);
        check_res("len0", 0, 0, 0);
        chk("len0_busy", 32'(busy), 32'd1);
        handshake("len0");

        // Gapped input, config change mid-frame, held result under backpressure
        vdat[0] = 16'd2; vdat[1] = 16'd11; vdat[2] = 16'd5; vdat[3] = 16'd11;
        for (int i = 0; i < 4; i++) vdv[i] = 1'b1;
        start_frame(4, 1'b1);
        cfg_great_n_small = 1'b0;
        cfg_len = 5'd2;
        send_frame(4, 1'b1);
        check_res("bp", 11, 1, 1);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            @(negedge clk);
            chk("bp_hold_vld", 32'(res_vld), 32'd1);
            chk("bp_hold_dat", 32'(res_dat), 32'd11);
            chk("bp_hold_idx", 32'(res_idx), 32'd1);
        end
        start = 1'b1;
        res_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_rdy = 1'b0;
        chk("bp_hs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bp_start_ignored", 32'(busy), 32'd0);

        // Next frame after handshake works normally
        vdat[0] = 16'd42; vdv[0] = 1'b1;
        start_frame(1, 1'b0);
        send_frame(1, 1'b0);
        check_res("one", 42, 0, 1);
        handshake("one");

        // Asynchronous reset in the middle of a frame
        vdat[0] = 16'd50; vdat[1] = 16'd60;
        start_frame(4, 1'b1);
        send_frame(2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_rdy", 32'(in_rdy), 32'd0);
        chk("mrst_res_dat", 32'(res_dat), 32'd0);
        chk("mrst_res_dv", 32'(res_dv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_idle", 32'(busy), 32'd0);
        vdat[0] = 16'd5; vdat[1] = 16'd9; vdv[0] = 1'b1; vdv[1] = 1'b1;
        start_frame(2, 1'b0);
        send_frame(2, 1'b0);
        check_res("post_rst", 5, 0, 1);
        handshake("post_rst");

`ifdef COMP_SCAN_SECOND_EN
        // Runner-up tracking, tie on the best value goes to second
        vdat[0] = 16'd4; vdat[1] = 16'd8; vdat[2] = 16'd6; vdat[3] = 16'd8;
        for (int i = 0; i < 4; i++) vdv[i] = 1'b1;
        start_frame(4, 1'b1);
        send_frame(4, 1'b0);
        check_res("sec", 8, 1, 1);
        chk("sec2_dat", 32'(res2_dat), 32'd8);
        chk("sec2_idx", 32'(res2_idx), 32'd3);
        chk("sec2_dv", 32'(res2_dv), 32'd1);
        handshake("sec");
        vdat[0] = 16'd4; vdv[0] = 1'b1;
        start_frame(1, 1'b1);
        send_frame(1, 1'b0);
        chk("sec_one_dv", 32'(res2_dv), 32'd0);
        handshake("sec_one");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
